// File: rtl/sw_debounce_pkg.sv
// sw_debounce_pkg: shared types and sizing helpers for the switch debouncer.
// Optional edge statistics are enabled with SW_DEBOUNCE_STATS_EN.
package sw_debounce_pkg;
   typedef enum logic {ST_STABLE, ST_SETTLING} deb_state_t;
   localparam int EDGE_CNT_W = 8;
   function automatic int cnt_width(input int stable_cycles);
      return ($clog2(stable_cycles) < 1) ? 1 : $clog2(stable_cycles);
   endfunction
endpackage

// File: rtl/sw_debounce_if.sv
// sw_debounce_if: switch inputs, debounced levels and edge pulses.
// stat_clr/edge_cnt exist only when SW_DEBOUNCE_STATS_EN is defined.
interface sw_debounce_if import sw_debounce_pkg::*; #(parameter int N = 2);
   logic [N-1:0] sw_in;
   logic [N-1:0] sw_out;
   logic [N-1:0] rise;
   logic [N-1:0] fall;
`ifdef SW_DEBOUNCE_STATS_EN
   logic                    stat_clr;
   logic [N*EDGE_CNT_W-1:0] edge_cnt;
   modport master(output sw_in, stat_clr, input sw_out, rise, fall, edge_cnt);
   modport slave(input sw_in, stat_clr, output sw_out, rise, fall, edge_cnt);
`else
   modport master(output sw_in, input sw_out, rise, fall);
   modport slave(input sw_in, output sw_out, rise, fall);
`endif
endinterface

// File: rtl/sw_debounce_ch.sv
// sw_debounce_ch: one channel - synchroniser, settle timer, level and pulse regs.
// Saturating edge counter present when SW_DEBOUNCE_STATS_EN is defined.
module sw_debounce_ch import sw_debounce_pkg::*; #(
   parameter int STABLE_CYCLES = 16,
   parameter int SYNC_STAGES   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_sw,
`ifdef SW_DEBOUNCE_STATS_EN
   input  logic                  i_clr,
   output logic [EDGE_CNT_W-1:0] o_cnt,
`endif
   output logic                  o_sw,
   output logic                  o_rise,
   output logic                  o_fall
);
   localparam int CNT_W = cnt_width(STABLE_CYCLES);
   logic [SYNC_STAGES-1:0] r_sync;
   logic [CNT_W-1:0]       r_cnt;
   deb_state_t             r_state;
   logic                   r_out, r_rise, r_fall;
   logic                   w_sync, w_commit;
   assign w_sync   = r_sync[SYNC_STAGES-1];
   assign w_commit = r_state == ST_SETTLING && w_sync != r_out && r_cnt == CNT_W'(STABLE_CYCLES - 1);
   always_ff @(posedge clk or negedge rst)
      if (!rst) r_sync <= '0;
      else      r_sync <= {r_sync[SYNC_STAGES-2:0], i_sw};
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_state <= ST_STABLE;
         r_cnt   <= '0;
         r_out   <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_rise  <= w_commit & w_sync;
         r_fall  <= w_commit & ~w_sync;
         r_out   <= w_commit ? w_sync : r_out;
         r_state <= (r_state == ST_STABLE) ? ((w_sync != r_out) ? ST_SETTLING : ST_STABLE)
                                           : ((w_sync == r_out || w_commit) ? ST_STABLE : ST_SETTLING);
         // the timer only runs while a differing level persists; any exit restarts it
         r_cnt   <= (r_state == ST_SETTLING && w_sync != r_out && !w_commit) ? r_cnt + 1'b1 : '0;
      end
`ifdef SW_DEBOUNCE_STATS_EN
   logic [EDGE_CNT_W-1:0] r_ecnt;
   always_ff @(posedge clk or negedge rst)
      if (!rst)                        r_ecnt <= '0;
      else if (i_clr)                  r_ecnt <= '0;
      else if (w_commit && ~&r_ecnt)   r_ecnt <= r_ecnt + 1'b1;
   assign o_cnt = r_ecnt;
`endif
   assign o_sw   = r_out;
   assign o_rise = r_rise;
   assign o_fall = r_fall;
endmodule

// File: rtl/sw_debounce.sv
// sw_debounce: N independent debounced switch channels feeding operands a (bit 0) and b (bit 1).
// Build with SW_DEBOUNCE_STATS_EN to add per-channel committed-edge counters.
module sw_debounce import sw_debounce_pkg::*; #(
   parameter int N             = 2,
   parameter int STABLE_CYCLES = 16,
   parameter int SYNC_STAGES   = 2
) (
   input logic         clk,
   input logic         rst,
   sw_debounce_if.slave bus
);
   logic [N-1:0] w_out, w_rise, w_fall;
`ifdef SW_DEBOUNCE_STATS_EN
   logic [N*EDGE_CNT_W-1:0] w_cnt;
   assign bus.edge_cnt = w_cnt;
`endif
   for (genvar i = 0; i < N; i++) begin : g_ch
      sw_debounce_ch #(.STABLE_CYCLES(STABLE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_ch (
         .clk    (clk),
         .rst    (rst),
         .i_sw   (bus.sw_in[i]),
`ifdef SW_DEBOUNCE_STATS_EN
         .i_clr  (bus.stat_clr),
         .o_cnt  (w_cnt[i*EDGE_CNT_W +: EDGE_CNT_W]),
`endif
         .o_sw   (w_out[i]),
         .o_rise (w_rise[i]),
         .o_fall (w_fall[i])
      );
   end
   assign bus.sw_out = w_out;
   assign bus.rise   = w_rise;
   assign bus.fall   = w_fall;
endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: defaults DUT and a STABLE_CYCLES=2/SYNC_STAGES=3 DUT share one stimulus.
// Edge statistics are checked when SW_DEBOUNCE_STATS_EN is defined.
module tb_sw_debounce;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] sw  = 2'b00;
   logic       clr = 1'b0;
   int checks = 0, failures = 0;
   int sc [2] = '{16, 2};
   int sy [2] = '{2, 3};
   bit dl [2][2][4];
   bit m_out [2][2], m_rise [2][2], m_fall [2][2];
   int run [2][2], m_ec [2][2];

   always #5 clk = ~clk;

   sw_debounce_if #(.N(2)) bus0 ();
   sw_debounce_if #(.N(2)) bus1 ();
   assign bus0.sw_in = sw;
   assign bus1.sw_in = sw;
`ifdef SW_DEBOUNCE_STATS_EN
   assign bus0.stat_clr = clr;
   assign bus1.stat_clr = clr;
`endif
   sw_debounce #(.N(2), .STABLE_CYCLES(16), .SYNC_STAGES(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
   sw_debounce #(.N(2), .STABLE_CYCLES(2),  .SYNC_STAGES(3)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   task automatic chk(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Model: sw_out follows the delayed input once it has disagreed for STABLE_CYCLES+1 samples in a row
   task automatic mreset();
      for (int k = 0; k < 2; k++)
         for (int c = 0; c < 2; c++) begin
            for (int j = 0; j < 4; j++) dl[k][c][j] = 1'b0;
            m_out[k][c] = 0; m_rise[k][c] = 0; m_fall[k][c] = 0;
            run[k][c] = 0; m_ec[k][c] = 0;
         end
   endtask

   task automatic mstep();
      bit u, commit;
      for (int k = 0; k < 2; k++)
         for (int c = 0; c < 2; c++) begin
            u = dl[k][c][sy[k]-1];
            for (int j = 3; j > 0; j--) dl[k][c][j] = dl[k][c][j-1];
            dl[k][c][0] = sw[c];
            run[k][c] = (u != m_out[k][c]) ? run[k][c] + 1 : 0;
            commit = run[k][c] == sc[k] + 1;
            m_rise[k][c] = commit && u;
            m_fall[k][c] = commit && !u;
            if (commit) begin
               m_out[k][c] = u;
               run[k][c] = 0;
            end
            if (clr) m_ec[k][c] = 0;
            else if (commit && m_ec[k][c] < 255) m_ec[k][c]++;
         end
   endtask

   initial begin
      logic [1:0] a_out, a_rise, a_fall;
      mreset();
      forever begin
         @(posedge clk);
         if (!rst) mreset(); else mstep();
         #2;
         if (!rst) mreset();
         for (int k = 0; k < 2; k++) begin
            a_out  = k == 0 ? bus0.sw_out : bus1.sw_out;
            a_rise = k == 0 ? bus0.rise   : bus1.rise;
            a_fall = k == 0 ? bus0.fall   : bus1.fall;
            chk($sformatf("d%0d_out", k),  a_out,  {m_out[k][1],  m_out[k][0]});
            chk($sformatf("d%0d_rise", k), a_rise, {m_rise[k][1], m_rise[k][0]});
            chk($sformatf("d%0d_fall", k), a_fall, {m_fall[k][1], m_fall[k][0]});
`ifdef SW_DEBOUNCE_STATS_EN
            chk($sformatf("d%0d_ecnt", k), k == 0 ? bus0.edge_cnt : bus1.edge_cnt, {m_ec[k][1][7:0], m_ec[k][0][7:0]});
`endif
         end
      end
   end

   initial begin
      #800000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      int n;
      repeat (6) begin @(negedge clk); sw = ~sw; end
      chk("rst_hold_out", bus0.sw_out, 0);
      chk("rst_hold_pulse", {bus0.rise, bus0.fall}, 0);
      @(negedge clk); sw = 2'b00; #1 rst = 1'b1;
      tick(5);
      // clean press on channel 0
      sw = 2'b01;
      tick(5);  chk("d1_e4_out", bus1.sw_out, 0);
      tick(1);  chk("d1_e5_out", bus1.sw_out, 1);  chk("d1_e5_rise", bus1.rise, 1);
      tick(1);  chk("d1_e6_rise", bus1.rise, 0);
      tick(11); chk("d0_e17_out", bus0.sw_out, 0);
      tick(1);  chk("d0_e18_out", bus0.sw_out, 1); chk("d0_e18_rise", bus0.rise, 1); chk("d0_e18_fall", bus0.fall, 0);
      tick(1);  chk("d0_e19_rise", bus0.rise, 0);  chk("d0_e19_out", bus0.sw_out, 1);
      // bounce on channel 1
      sw[1] = 1'b1; tick(10); sw[1] = 1'b0; tick(3); sw[1] = 1'b1; tick(10); sw[1] = 1'b0;
      tick(30); chk("bounce_out", bus0.sw_out, 1);
      sw[1] = 1'b1; n = 0;
      repeat (25) begin tick(1); n += int'(bus0.rise[1]); end
      chk("bounce_single_rise", n, 1); chk("bounce_out_hi", bus0.sw_out, 3);
      // simultaneous channels
      sw = 2'b00; tick(30); chk("sim_idle", bus0.sw_out, 0);
      sw = 2'b11; n = 0;
      while (bus0.rise == 0 && n < 40) begin tick(1); n++; end
      chk("sim_rise", bus0.rise, 3); chk("sim_rise_out", bus0.sw_out, 3);
      tick(1); chk("sim_rise_once", bus0.rise, 0);
      sw = 2'b00; n = 0;
      while (bus0.fall == 0 && n < 40) begin tick(1); n++; end
      chk("sim_fall", bus0.fall, 3); chk("sim_fall_out", bus0.sw_out, 0);
      tick(1); chk("sim_fall_once", bus0.fall, 0);
      // one-cycle glitch on the short-window DUT
      tick(10); sw[0] = 1'b1; tick(1); sw[0] = 1'b0; tick(10);
      chk("d1_glitch_out", bus1.sw_out, 0);
      // reset while settling a fall
      sw = 2'b11; tick(30); chk("pre_rst_out", bus0.sw_out, 3);
      sw = 2'b00; tick(8);
      #1 rst = 1'b0;
      #1 chk("rst_async_d0", bus0.sw_out, 0); chk("rst_async_d1", bus1.sw_out, 0);
      @(negedge clk); #1 rst = 1'b1;
      n = 0;
      repeat (30) begin tick(1); n += int'(|{bus0.rise, bus0.fall}); end
      chk("rst_no_pulse", n, 0);
      // release reset with switches already high
      @(negedge clk); #1 rst = 1'b0; sw = 2'b11; tick(3); #1 rst = 1'b1;
      tick(25); chk("rel_high_out", bus0.sw_out, 3);
`ifdef SW_DEBOUNCE_STATS_EN
      repeat (300) begin sw[0] = ~sw[0]; tick(20); end
      chk("ecnt_sat_d0", bus0.edge_cnt[7:0], 255);
      chk("ecnt_sat_d1", bus1.edge_cnt[7:0], 255);
      sw[0] = ~sw[0]; tick(18); clr = 1'b1; tick(1); clr = 1'b0;
      chk("clr_commit_pulse", bus0.rise[0] | bus0.fall[0], 1);
      chk("clr_wins", bus0.edge_cnt[7:0], 0);
      tick(1); chk("clr_hold", bus0.edge_cnt, 0);
`endif
      tick(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
